// File: rtl/demux_stream_nch.sv
`default_nettype none
// ============================================================================
//  Module   : demux_stream_nch
//  Purpose  : Registered 1-to-NCH valid/ready stream demultiplexer. Each output
//             channel owns a 1-entry output register. In packet mode the
//             target channel is latched on the head beat and held until the
//             beat carrying in_last. Beats addressed to a channel index that
//             does not exist are consumed, dropped and counted.
//  Ports    : clk, rst          - clock (rising edge), synchronous active-high reset
//             in_valid/in_ready - input handshake
//             in_data/in_sel    - beat payload and target channel
//             in_last           - end of packet marker
//             out_valid/out_ready/out_data/out_last - per-channel outputs,
//                                 channel k at bit k / [k*WIDTH +: WIDTH]
//             drop_cnt          - saturating count of dropped beats
//  Revision : 1.0 - initial release
// ============================================================================
module demux_stream_nch #(
    parameter int WIDTH    = 8,
    parameter int NCH      = 4,
    parameter int SELW     = 2,
    parameter int PKT_MODE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_last,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_last,
    output logic [7:0]           drop_cnt
);

    localparam logic [SELW:0] c_NCH_EXT = (SELW+1)'(NCH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 state_q;
    logic [SELW-1:0]        sel_q;
    logic [NCH-1:0]         out_valid_q;
    logic [NCH*WIDTH-1:0]   out_data_q;
    logic [NCH-1:0]         out_last_q;
    logic [7:0]             drop_cnt_q;
    logic [7:0]             drop_cnt_d;

    logic [SELW-1:0]        w_tgt;
    logic                   w_tgt_ok;
    logic [NCH-1:0]         w_free;
    logic                   w_free_tgt;
    logic                   w_in_ready;
    logic                   w_accept;
    logic [NCH-1:0]         w_wr;

    // Mid-packet the latched channel wins; in_sel is only looked at on a head
    // beat (or on every beat when packet mode is off).
    assign w_tgt    = ((PKT_MODE != 0) && (state_q == ST_BUSY)) ? sel_q : in_sel;
    assign w_tgt_ok = ({1'b0, w_tgt} < c_NCH_EXT);

    // A slot can take a beat if it is empty or is being drained this cycle.
    assign w_free = ~out_valid_q | out_ready;

    // Mux the target slot's free flag without indexing past NCH-1.
    always_comb begin
        w_free_tgt = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (w_tgt == SELW'(k)) begin
                w_free_tgt = w_free[k];
            end
        end
    end

    // Nonexistent channels act as a sink that is always ready.
    assign w_in_ready = !rst && (w_tgt_ok ? w_free_tgt : 1'b1);
    assign w_accept   = in_valid && w_in_ready;

    // ------------------------------------------------------------------------
    // Per-channel output registers
    // ------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            assign w_wr[k] = w_accept && w_tgt_ok && (w_tgt == SELW'(k));

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q[k]                 <= 1'b0;
                    out_data_q[k*WIDTH +: WIDTH]   <= '0;
                    out_last_q[k]                  <= 1'b0;
                end else if (w_wr[k]) begin
                    // Fill wins over a simultaneous drain, so valid stays high.
                    out_valid_q[k]                 <= 1'b1;
                    out_data_q[k*WIDTH +: WIDTH]   <= in_data;
                    out_last_q[k]                  <= in_last;
                end else if (out_ready[k]) begin
                    // Data is left in place; only the valid flag clears.
                    out_valid_q[k]                 <= 1'b0;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Dropped-beat counter (saturating)
    // ------------------------------------------------------------------------
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (w_accept && !w_tgt_ok && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Packet FSM: latch the channel on a multi-beat head, release on in_last
    // ------------------------------------------------------------------------
    generate
        if (PKT_MODE != 0) begin : g_pkt
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_IDLE;
                    sel_q   <= '0;
                end else if (w_accept) begin
                    case (state_q)
                        ST_IDLE: begin
                            // Single-beat packets never leave IDLE.
                            if (!in_last) begin
                                state_q <= ST_BUSY;
                                sel_q   <= in_sel;
                            end
                        end
                        ST_BUSY: begin
                            if (in_last) begin
                                state_q <= ST_IDLE;
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end else begin : g_nopkt
            always_ff @(posedge clk) begin
                state_q <= ST_IDLE;
                sel_q   <= '0;
            end
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_stream_nch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_stream_nch
//  Purpose  : Self-checking bench. Instance A (NCH=4, per-beat select) is
//             driven from a table of vectors with hand-computed expectations.
//             Instance B (NCH=3, packet mode) is driven by directed sequences
//             and random traffic, checked against a queue-based scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux_stream_nch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: NCH=4, PKT_MODE=0 ----------------
    logic        rst_a, in_valid_a, in_ready_a, in_last_a;
    logic [7:0]  in_data_a;
    logic [1:0]  in_sel_a;
    logic [3:0]  out_valid_a, out_ready_a, out_last_a;
    logic [31:0] out_data_a;
    logic [7:0]  drop_cnt_a;

    demux_stream_nch #(.WIDTH(8), .NCH(4), .SELW(2), .PKT_MODE(0)) u_dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .in_data   (in_data_a),
        .in_sel    (in_sel_a),
        .in_last   (in_last_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_data  (out_data_a),
        .out_last  (out_last_a),
        .drop_cnt  (drop_cnt_a)
    );

    // ---------------- instance B: NCH=3, PKT_MODE=1 ----------------
    logic        rst_b, in_valid_b, in_ready_b, in_last_b;
    logic [7:0]  in_data_b;
    logic [1:0]  in_sel_b;
    logic [2:0]  out_valid_b, out_ready_b, out_last_b;
    logic [23:0] out_data_b;
    logic [7:0]  drop_cnt_b;

    demux_stream_nch #(.WIDTH(8), .NCH(3), .SELW(2), .PKT_MODE(1)) u_dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_data   (in_data_b),
        .in_sel    (in_sel_b),
        .in_last   (in_last_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_data  (out_data_b),
        .out_last  (out_last_b),
        .drop_cnt  (drop_cnt_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard for instance B ----------------
    // Each channel keeps a FIFO of accepted {last,data} beats still owed to the
    // consumer, plus the most recently written beat (what the port shows).
    logic [8:0] mq [3][$];
    logic [8:0] mheld [3];
    int         m_drop;
    bit         m_busy;
    int         m_sel;

    task automatic cyc_b(input logic r, input logic v, input logic [1:0] s,
                         input logic [7:0] d, input logic l, input logic [2:0] rdy);
        int         t;
        logic       er;
        logic       acc;
        logic [2:0] ev;
        logic [2:0] el;
        logic [23:0] ed;
        rst_b = r; in_valid_b = v; in_sel_b = s; in_data_b = d;
        in_last_b = l; out_ready_b = rdy;
        t  = m_busy ? m_sel : int'(s);
        if (r)          er = 1'b0;
        else if (t >= 3) er = 1'b1;
        else            er = (mq[t].size() == 0) || rdy[t];
        #2;
        chk("b_in_ready", {63'd0, in_ready_b}, {63'd0, er});
        acc = v && er;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 3; k++) begin
                mq[k].delete();
                mheld[k] = '0;
            end
            m_drop = 0; m_busy = 0; m_sel = 0;
        end else begin
            for (int k = 0; k < 3; k++)
                if (mq[k].size() != 0 && rdy[k]) void'(mq[k].pop_front());
            if (acc) begin
                if (t < 3) begin
                    mq[t].push_back({l, d});
                    mheld[t] = {l, d};
                end else if (m_drop < 255) begin
                    m_drop++;
                end
                if (!m_busy && !l) begin
                    m_busy = 1; m_sel = int'(s);
                end else if (m_busy && l) begin
                    m_busy = 0;
                end
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            ev[k]          = (mq[k].size() != 0);
            el[k]          = mheld[k][8];
            ed[k*8 +: 8]   = mheld[k][7:0];
        end
        chk("b_out_valid", {61'd0, out_valid_b}, {61'd0, ev});
        chk("b_out_data",  {40'd0, out_data_b},  {40'd0, ed});
        chk("b_out_last",  {61'd0, out_last_b},  {61'd0, el});
        chk("b_drop_cnt",  {56'd0, drop_cnt_b},  64'(m_drop));
    endtask

    // ---------------- vector table for instance A ----------------
    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [7:0] d;
        logic [3:0] rdy;
        logic       exp_rdy;
        logic [3:0] exp_valid;
        int         ch;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vt [16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected done by 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        // sweep one beat to each channel
        vt[0]  = '{1'b1, 2'd0, 8'hA0, 4'hF, 1'b1, 4'b0001, 0, 8'hA0};
        vt[1]  = '{1'b1, 2'd1, 8'hA1, 4'hF, 1'b1, 4'b0010, 1, 8'hA1};
        vt[2]  = '{1'b1, 2'd2, 8'hA2, 4'hF, 1'b1, 4'b0100, 2, 8'hA2};
        vt[3]  = '{1'b1, 2'd3, 8'hA3, 4'hF, 1'b1, 4'b1000, 3, 8'hA3};
        vt[4]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 3, 8'hA3};
        // ch2 stalled: second beat must wait, then follows in order
        vt[5]  = '{1'b1, 2'd2, 8'h11, 4'hB, 1'b1, 4'b0100, 2, 8'h11};
        vt[6]  = '{1'b1, 2'd2, 8'h22, 4'hB, 1'b0, 4'b0100, 2, 8'h11};
        vt[7]  = '{1'b1, 2'd2, 8'h22, 4'hF, 1'b1, 4'b0100, 2, 8'h22};
        vt[8]  = '{1'b0, 2'd2, 8'h00, 4'hF, 1'b1, 4'b0000, 2, 8'h22};
        // back-to-back fill while draining the same slot
        vt[9]  = '{1'b1, 2'd1, 8'h55, 4'hF, 1'b1, 4'b0010, 1, 8'h55};
        vt[10] = '{1'b1, 2'd1, 8'h66, 4'hF, 1'b1, 4'b0010, 1, 8'h66};
        vt[11] = '{1'b0, 2'd1, 8'h00, 4'hF, 1'b1, 4'b0000, 1, 8'h66};
        // stalled ch0 does not block ch3
        vt[12] = '{1'b1, 2'd0, 8'h77, 4'h0, 1'b1, 4'b0001, 0, 8'h77};
        vt[13] = '{1'b1, 2'd3, 8'h88, 4'h0, 1'b1, 4'b1001, 3, 8'h88};
        vt[14] = '{1'b1, 2'd0, 8'h99, 4'h0, 1'b0, 4'b1001, 0, 8'h77};
        vt[15] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 0, 8'h77};

        // ---------------- reset ----------------
        rst_a = 1'b1; in_valid_a = 1'b1; in_sel_a = 2'd0; in_data_a = 8'h5A;
        in_last_a = 1'b0; out_ready_a = 4'hF;
        rst_b = 1'b1; in_valid_b = 1'b0; in_sel_b = 2'd0; in_data_b = 8'h00;
        in_last_b = 1'b0; out_ready_b = 3'b000;
        m_drop = 0; m_busy = 0; m_sel = 0;
        for (int k = 0; k < 3; k++) mheld[k] = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("a_rst_in_ready",  {63'd0, in_ready_a},  64'd0);
        chk("a_rst_out_valid", {60'd0, out_valid_a}, 64'd0);
        chk("a_rst_out_data",  {32'd0, out_data_a},  64'd0);
        chk("a_rst_drop_cnt",  {56'd0, drop_cnt_a},  64'd0);
        rst_a = 1'b0; in_valid_a = 1'b0;
        cyc_b(1'b1, 1'b1, 2'd1, 8'hEE, 1'b0, 3'b111);
        cyc_b(1'b1, 1'b1, 2'd1, 8'hEE, 1'b0, 3'b111);

        // ---------------- instance A table ----------------
        for (int i = 0; i < 16; i++) begin
            in_valid_a = vt[i].v; in_sel_a = vt[i].sel;
            in_data_a = vt[i].d;  out_ready_a = vt[i].rdy;
            #2;
            chk($sformatf("a_vec%0d_in_ready", i), {63'd0, in_ready_a}, {63'd0, vt[i].exp_rdy});
            @(posedge clk); #1;
            chk($sformatf("a_vec%0d_out_valid", i), {60'd0, out_valid_a}, {60'd0, vt[i].exp_valid});
            chk($sformatf("a_vec%0d_out_data", i), {56'd0, out_data_a[vt[i].ch*8 +: 8]}, {56'd0, vt[i].exp_d});
        end
        chk("a_out_last", {60'd0, out_last_a}, 64'd0);
        chk("a_drop_cnt", {56'd0, drop_cnt_a}, 64'd0);
        in_valid_a = 1'b0;

        // ---------------- B: packet latched on head ----------------
        cyc_b(1'b0, 1'b1, 2'd1, 8'h31, 1'b0, 3'b111);
        chk("t3_b1_valid", {61'd0, out_valid_b}, 64'b010);
        chk("t3_b1_data",  {56'd0, out_data_b[15:8]}, 64'h31);
        cyc_b(1'b0, 1'b1, 2'd3, 8'h32, 1'b0, 3'b111);
        chk("t3_b2_valid", {61'd0, out_valid_b}, 64'b010);
        chk("t3_b2_last",  {61'd0, out_last_b},  64'b000);
        cyc_b(1'b0, 1'b1, 2'd3, 8'h33, 1'b1, 3'b111);
        chk("t3_b3_data",  {56'd0, out_data_b[15:8]}, 64'h33);
        chk("t3_b3_last",  {61'd0, out_last_b},  64'b010);
        cyc_b(1'b0, 1'b1, 2'd2, 8'h34, 1'b1, 3'b111);
        chk("t3_next_valid", {61'd0, out_valid_b}, 64'b100);

        // ---------------- B: invalid select, saturation ----------------
        for (int i = 0; i < 300; i++)
            cyc_b(1'b0, 1'b1, 2'd3, 8'(i), 1'b1, 3'b111);
        chk("t4_drop_sat",  {56'd0, drop_cnt_b},  64'd255);
        chk("t4_no_valid",  {61'd0, out_valid_b}, 64'd0);

        // ---------------- B: reset mid-packet ----------------
        cyc_b(1'b0, 1'b1, 2'd0, 8'h51, 1'b0, 3'b111);
        cyc_b(1'b0, 1'b1, 2'd2, 8'h52, 1'b0, 3'b111);
        chk("t5_mid_valid", {61'd0, out_valid_b}, 64'b001);
        cyc_b(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000);
        chk("t5_rst_valid", {61'd0, out_valid_b}, 64'd0);
        chk("t5_rst_drop",  {56'd0, drop_cnt_b},  64'd0);
        cyc_b(1'b0, 1'b1, 2'd2, 8'h53, 1'b1, 3'b111);
        chk("t5_head_valid", {61'd0, out_valid_b}, 64'b100);
        chk("t5_head_data",  {56'd0, out_data_b[23:16]}, 64'h53);

        // ---------------- B: random traffic ----------------
        for (int i = 0; i < 2000; i++) begin
            cyc_b(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)),
                  8'($urandom),
                  ($urandom_range(0, 3) == 0),
                  3'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
